// File: rtl/rom_burst_writer.sv
// Burst writer for a 2**ADDR_W x DATA_W byte table with a registered read port.
// Latency: one write per accepted beat, rd_data one cycle after rd_addr; in_ready drops during abort and outside LOAD.
module rom_burst_writer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     remaining;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                count_ok;
  logic                beat;

  assign count_ok = (count != '0) && (count <= (ADDR_W+1)'(DEPTH));
  assign beat     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = count_ok ? LOAD : DONE;
      LOAD: if (abort || (beat && remaining == (ADDR_W+1)'(1))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Abort wins over a same-cycle beat by withholding in_ready.
  always_comb begin
    in_ready = (state == LOAD) && !abort;
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      remaining <= '0;
      checksum  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (count_ok) begin
            wr_ptr    <= base_addr;
            remaining <= count;
            checksum  <= '0;
            err       <= 1'b0;
          end else begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            err <= 1'b1;
          end else if (beat) begin
            wr_ptr    <= wr_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            checksum  <= checksum + in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (beat) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Read samples the array before this edge's write lands: old data on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_rom_burst_writer.sv
// Directed and randomized bursts against a transaction-level table model.
module tb_rom_burst_writer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] checksum;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  int passed = 0;
  int total  = 0;

  logic [7:0] ref_mem [16];
  logic [7:0] ref_sum;
  logic       ref_err;

  rom_burst_writer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .err(err),
    .checksum(checksum), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dump_mem();
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      step();
      chk($sformatf("mem[%0d]", k), {24'd0, rd_data}, {24'd0, ref_mem[k]});
    end
  endtask

  // One burst; the model writes each accepted byte to (base + n) mod 16.
  task automatic run_burst(input logic [3:0] base, input logic [4:0] cnt, input int abort_at,
                           input bit fixed, input logic [7:0] d0, input logic [7:0] dstep,
                           input bit rndv, input logic [15:0] vmask);
    int         beats = 0;
    int         cyc   = 0;
    bit         fin   = 0;
    logic [7:0] sum   = 8'd0;
    logic [3:0] a     = base;
    bit         ok    = (cnt >= 5'd1) && (cnt <= 5'd16);
    start = 1'b1; base_addr = base; count = cnt;
    step();
    start = 1'b0;
    if (!ok) begin
      chk("bad_done", {31'd0, done}, 1);
      chk("bad_err", {31'd0, err}, 1);
      chk("bad_ready", {31'd0, in_ready}, 0);
      step();
      chk("bad_done_clr", {31'd0, done}, 0);
      chk("bad_idle", {31'd0, busy}, 0);
      chk("bad_csum_kept", {24'd0, checksum}, {24'd0, ref_sum});
      ref_err = 1'b1;
      return;
    end
    ref_err = 1'b0;
    chk("load_busy", {31'd0, busy}, 1);
    chk("load_err_clr", {31'd0, err}, 0);
    chk("load_csum_clr", {24'd0, checksum}, 0);
    while (!fin) begin
      in_valid  = rndv ? 1'($urandom % 2) : vmask[cyc % 16];
      in_data   = fixed ? 8'(d0 + dstep * 8'(beats)) : 8'($urandom);
      abort     = in_valid && (beats == abort_at);
      start     = ($urandom % 4) == 0;
      base_addr = 4'($urandom);
      count     = 5'($urandom_range(1, 16));
      a         = 4'(base + 4'(beats));
      rd_addr   = a;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !abort});
      chk("load_done_low", {31'd0, done}, 0);
      step();
      chk("rd_old", {24'd0, rd_data}, {24'd0, ref_mem[a]});
      if (abort) begin
        ref_err = 1'b1;
        fin = 1;
      end else if (in_valid) begin
        ref_mem[a] = in_data;
        sum = sum + in_data;
        beats++;
        if (beats == int'(cnt)) fin = 1;
      end
      cyc++;
      if (!fin && cyc > 300) begin
        chk("burst_timeout", 0, 1);
        fin = 1;
      end
    end
    start = 1'b0; in_valid = 1'b0; abort = 1'b0;
    #1;
    chk("done_pulse", {31'd0, done}, 1);
    chk("done_busy", {31'd0, busy}, 1);
    chk("done_ready", {31'd0, in_ready}, 0);
    chk("done_err", {31'd0, err}, {31'd0, ref_err});
    rd_addr = a;
    step();
    chk("rd_new", {24'd0, rd_data}, {24'd0, ref_mem[a]});
    chk("done_clr", {31'd0, done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("checksum", {24'd0, checksum}, {24'd0, sum});
    ref_sum = sum;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; rd_addr = '0;
    for (int k = 0; k < 16; k++) ref_mem[k] = 8'd0;
    ref_sum = 8'd0; ref_err = 1'b0;
    #3;
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_csum", {24'd0, checksum}, 0);
    chk("rst_rd", {24'd0, rd_data}, 0);
    #10 rst_n = 1'b1;
    step();

    // full table 00,11,..,FF from address 0
    run_burst(4'd0, 5'd16, -1, 1, 8'h00, 8'h11, 0, 16'hFFFF);
    dump_mem();
    // wrap from 14
    run_burst(4'd14, 5'd4, -1, 1, 8'hA1, 8'h01, 0, 16'hFFFF);
    dump_mem();
    // gappy valid 1,0,0,1,1
    run_burst(4'd5, 5'd3, -1, 0, 8'h00, 8'h00, 0, 16'h0019);
    // zero and oversize counts, then a good start clears err
    run_burst(4'd2, 5'd0, -1, 0, 8'h00, 8'h00, 1, 16'h0000);
    run_burst(4'd7, 5'd17, -1, 0, 8'h00, 8'h00, 1, 16'h0000);
    run_burst(4'd9, 5'd2, -1, 0, 8'h00, 8'h00, 0, 16'hFFFF);
    // abort on the third byte of five
    run_burst(4'd8, 5'd5, 2, 0, 8'h00, 8'h00, 0, 16'hFFFF);
    dump_mem();

    repeat (10) begin
      logic [4:0] c;
      int ab;
      c  = 5'($urandom_range(1, 16));
      ab = (($urandom % 3) == 0) ? int'($urandom_range(0, int'(c) - 1)) : -1;
      run_burst(4'($urandom), c, ab, 0, 8'h00, 8'h00, 1, 16'h0000);
    end
    run_burst(4'($urandom), 5'($urandom_range(17, 31)), -1, 0, 8'h00, 8'h00, 1, 16'h0000);
    dump_mem();

    // reset in the middle of a burst
    start = 1'b1; base_addr = 4'd3; count = 5'd8;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_data = 8'hC3;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_err", {31'd0, err}, 0);
    chk("mid_rst_csum", {24'd0, checksum}, 0);
    chk("mid_rst_rd", {24'd0, rd_data}, 0);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) ref_mem[k] = 8'd0;
    ref_sum = 8'd0; ref_err = 1'b0;
    #4 rst_n = 1'b1;
    step();
    chk("post_rst_idle", {31'd0, busy}, 0);
    dump_mem();
    run_burst(4'd15, 5'd3, -1, 0, 8'h00, 8'h00, 1, 16'h0000);
    dump_mem();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
